// File: rtl/song_addr_sequencer.sv
// Multi-slot sample-address sequencer between the song FSM and the ZBT port.
// Optional build macro LOOP_PLAYBACK_EN: playback wraps to the slot base instead of finishing.
module song_addr_sequencer #(
  parameter int ADDR_W    = 19,
  parameter int NUM_SLOTS = 12,
  parameter int SEL_W     = 4,
  parameter int SLOT_SIZE = 40000,
  parameter int LEN_W     = 16,
  parameter int BASE_ADDR = 0,
  parameter int DECIM     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_strobe,
  input  logic              start,
  input  logic              pause,
  input  logic              record_mode,
  input  logic [SEL_W-1:0]  slot_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_strobe,
  output logic              mem_we,
  output logic              busy,
  output logic              song_done,
  output logic              bad_slot,
  output logic [LEN_W-1:0]  slot_len
);

`ifdef LOOP_PLAYBACK_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam int DCNT_W = $clog2(DECIM + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t            state;
  logic [DCNT_W-1:0] dcnt;
  logic [SEL_W-1:0]  sel_q;
  logic              rec_q;
  logic [LEN_W-1:0]  len_q [NUM_SLOTS];
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] end_addr;
  logic              sel_ok;

  function automatic logic [ADDR_W-1:0] slot_base(input logic [SEL_W-1:0] s);
    return ADDR_W'(BASE_ADDR + 32'(s) * SLOT_SIZE);
  endfunction

  function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] l);
    if (l >= LEN_W'(SLOT_SIZE))
      return l;
    else
      return l + LEN_W'(1);
  endfunction

  // A record take may fill the whole slot; playback stops at the last recorded word.
  always_comb begin
    base_q   = slot_base(sel_q);
    end_addr = rec_q ? base_q + ADDR_W'(SLOT_SIZE - 1)
                     : base_q + ADDR_W'(len_q[sel_q]) - ADDR_W'(1);
  end

  assign sel_ok    = 32'(slot_sel) < NUM_SLOTS;
  assign busy      = (state == RUN) || (state == PAUSE);
  assign song_done = (state == IDLE) || (state == DONE);
  assign slot_len  = len_q[sel_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mem_addr   <= ADDR_W'(BASE_ADDR);
      mem_strobe <= 1'b0;
      mem_we     <= 1'b0;
      bad_slot   <= 1'b0;
      dcnt       <= '0;
      sel_q      <= '0;
      rec_q      <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) len_q[i] <= '0;
    end else begin
      bad_slot <= 1'b0;
      if (start && sel_ok) begin
        // A valid start overrides everything, including a commit in flight.
        sel_q      <= slot_sel;
        rec_q      <= record_mode;
        mem_addr   <= slot_base(slot_sel);
        dcnt       <= '0;
        mem_strobe <= 1'b0;
        mem_we     <= 1'b0;
        if (record_mode) begin
          len_q[slot_sel] <= '0;
          state           <= RUN;
        end else if (len_q[slot_sel] == '0) begin
          state <= DONE;
        end else begin
          state <= RUN;
        end
      end else begin
        if (start) bad_slot <= 1'b1;
        unique case (state)
          RUN: begin
            if (mem_strobe) begin
              // Commit edge: runs to completion even if pause rose this cycle.
              mem_strobe <= 1'b0;
              mem_we     <= 1'b0;
              if (rec_q) len_q[sel_q] <= len_sat_inc(len_q[sel_q]);
              if (mem_addr == end_addr) begin
                if (LOOP_EN && !rec_q) begin
                  mem_addr <= base_q;
                  if (pause) state <= PAUSE;
                end else begin
                  state <= DONE;
                end
              end else begin
                mem_addr <= mem_addr + ADDR_W'(1);
                if (pause) state <= PAUSE;
              end
            end else if (pause) begin
              state <= PAUSE;
            end else if (sample_strobe) begin
              if (dcnt == DCNT_W'(DECIM - 1)) begin
                dcnt       <= '0;
                mem_strobe <= 1'b1;
                mem_we     <= rec_q;
              end else begin
                dcnt <= dcnt + DCNT_W'(1);
              end
            end
          end
          PAUSE: begin
            if (!pause) state <= RUN;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_addr_sequencer.sv
// Directed bench for song_addr_sequencer: small slots, DECIM=2, one strobe every 4 cycles.
module tb_song_addr_sequencer;

`ifdef LOOP_PLAYBACK_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, sample_strobe, start, start3, pause, record_mode;
  logic [1:0] slot_sel;

  logic [4:0] mem_addr, d3_addr;
  logic       mem_strobe, mem_we, busy, song_done, bad_slot;
  logic       d3_strobe, d3_we, d3_busy, d3_done, d3_bad;
  logic [3:0] slot_len, d3_len;

  int errors = 0;
  int checks = 0;

  logic [4:0] addrs[$];
  logic       wes[$];

  always #5 clk = ~clk;

  song_addr_sequencer #(
    .ADDR_W(5), .NUM_SLOTS(4), .SEL_W(2), .SLOT_SIZE(8), .LEN_W(4), .BASE_ADDR(0), .DECIM(2)
  ) dut (
    .clk(clk), .reset(reset), .sample_strobe(sample_strobe), .start(start), .pause(pause),
    .record_mode(record_mode), .slot_sel(slot_sel), .mem_addr(mem_addr), .mem_strobe(mem_strobe),
    .mem_we(mem_we), .busy(busy), .song_done(song_done), .bad_slot(bad_slot), .slot_len(slot_len)
  );

  song_addr_sequencer #(
    .ADDR_W(5), .NUM_SLOTS(3), .SEL_W(2), .SLOT_SIZE(8), .LEN_W(4), .BASE_ADDR(0), .DECIM(2)
  ) dut3 (
    .clk(clk), .reset(reset), .sample_strobe(sample_strobe), .start(start3), .pause(pause),
    .record_mode(record_mode), .slot_sel(slot_sel), .mem_addr(d3_addr), .mem_strobe(d3_strobe),
    .mem_we(d3_we), .busy(d3_busy), .song_done(d3_done), .bad_slot(d3_bad), .slot_len(d3_len)
  );

  // Record every transferred word of the main instance.
  always @(negedge clk) begin
    if (mem_strobe) begin
      addrs.push_back(mem_addr);
      wes.push_back(mem_we);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
      tick();
      tick();
      tick();
    end
  endtask

  task automatic start_slot(input logic [1:0] sel, input logic rec);
    slot_sel    = sel;
    record_mode = rec;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic clear_log();
    addrs.delete();
    wes.delete();
  endtask

  initial begin
    reset = 1'b1; sample_strobe = 1'b0; start = 1'b0; start3 = 1'b0;
    pause = 1'b0; record_mode = 1'b0; slot_sel = 2'd0;
    tick(); tick();
    reset = 1'b0;
    tick();

    check("rst_done", song_done, 1);
    check("rst_busy", busy, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_strobe", mem_strobe, 0);
    check("rst_bad", bad_slot, 0);
    check("rst_len", slot_len, 0);

    // Invalid slot on the 3-slot instance while it is busy recording slot 0.
    slot_sel = 2'd0; record_mode = 1'b1; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check("d3_run_busy", d3_busy, 1);
    slot_sel = 2'd3; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check("d3_bad_pulse", d3_bad, 1);
    check("d3_bad_busy", d3_busy, 1);
    check("d3_bad_addr", d3_addr, 0);
    check("d3_bad_done", d3_done, 0);
    tick();
    check("d3_bad_clear", d3_bad, 0);

    // Playback of an empty slot finishes immediately.
    clear_log();
    start_slot(2'd2, 1'b0);
    tick();
    check("empty_done", song_done, 1);
    check("empty_busy", busy, 0);
    check("empty_bad", bad_slot, 0);
    strobes(4);
    check("empty_nostrobe", addrs.size(), 0);

    // Record slot 1 to the slot end.
    clear_log();
    start_slot(2'd1, 1'b1);
    check("rec1_busy", busy, 1);
    check("rec1_done0", song_done, 0);
    check("rec1_base", mem_addr, 8);
    strobes(16);
    check("rec1_words", addrs.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check("rec1_addr", addrs[i], 8 + i);
      check("rec1_we", wes[i], 1);
    end
    check("rec1_done", song_done, 1);
    check("rec1_len", slot_len, 8);
    check("rec1_hold", mem_addr, 15);
    strobes(2);
    check("rec1_after", addrs.size(), 8);

    // Record slot 3, restart after 3 words, stop after 5.
    clear_log();
    start_slot(2'd3, 1'b1);
    strobes(6);
    check("rec3_take1_len", slot_len, 3);
    start_slot(2'd3, 1'b1);
    check("rec3_restart_addr", mem_addr, 24);
    check("rec3_restart_len", slot_len, 0);
    strobes(10);
    check("rec3_words", addrs.size(), 8);
    check("rec3_addr2", addrs[2], 26);
    check("rec3_addr3", addrs[3], 24);
    check("rec3_addr7", addrs[7], 28);
    start_slot(2'd3, 1'b0);
    check("rec3_len", slot_len, 5);
    check("play3_base", mem_addr, 24);

    // Playback of slot 3.
    clear_log();
    strobes(10);
    check("play3_words", addrs.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check("play3_addr", addrs[i], 24 + i);
      check("play3_we", wes[i], 0);
    end
    check("play3_done", song_done, LOOP ? 0 : 1);
    check("play3_end_addr", mem_addr, LOOP ? 24 : 28);

    // Pause after one strobe of the first word.
    clear_log();
    start_slot(2'd1, 1'b0);
    check("play1_len", slot_len, 8);
    strobes(1);
    pause = 1'b1;
    strobes(3);
    check("pause_nostrobe", addrs.size(), 0);
    check("pause_busy", busy, 1);
    check("pause_addr", mem_addr, 8);
    pause = 1'b0;
    tick();
    strobes(1);
    check("resume_commit", addrs.size(), 1);
    check("resume_addr", addrs[0], 8);
    strobes(1);
    check("resume_count", addrs.size(), 1);
    strobes(1);
    check("resume_next", addrs.size(), 2);
    check("resume_next_addr", addrs[1], 9);

`ifdef LOOP_PLAYBACK_EN
    // Three full loops over slot 1.
    clear_log();
    start_slot(2'd1, 1'b0);
    strobes(48);
    check("loop_words", addrs.size(), 24);
    for (int i = 0; i < 24; i++) check("loop_addr", addrs[i], 8 + (i % 8));
    check("loop_done", song_done, 0);
    check("loop_busy", busy, 1);
    check("loop_wrap_addr", mem_addr, 8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
